// File: rtl/decode_fetch_queue.sv
// Fetch-to-decode instruction queue: a circular buffer of DEPTH {instr, pc} entries
// with valid/ready handshakes on both sides. The head word is split into decode fields,
// and a canonical NOP is presented whenever the queue is empty or being flushed.
module decode_fetch_queue #(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     flush_in,
    input  logic [31:0]              instr_in,
    input  logic [XLEN-1:0]          pc_in,
    input  logic                     instr_valid_in,
    output logic                     instr_ready_out,
    input  logic                     dec_ready_in,
    output logic                     dec_valid_out,
    output logic [XLEN-1:0]          pc_out,
    output logic [6:0]               opcode_out,
    output logic [2:0]               funct3_out,
    output logic [6:0]               funct7_out,
    output logic [4:0]               rs1_addr_out,
    output logic [4:0]               rs2_addr_out,
    output logic [4:0]               rd_addr_out,
    output logic [11:0]              csr_addr_out,
    output logic [24:0]              instr_31_7_out,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [31:0]     instr_q [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic push, pop;
    logic [31:0] word;

    // Handshake decode, head selection and next-state for pointers and occupancy.
    always_comb begin
        // Ready is derived from registered state only; a same-cycle pop never frees a slot.
        instr_ready_out = (count_q < CntW'(DEPTH)) && !flush_in && !reset_in;
        dec_valid_out   = (count_q != '0) && !flush_in;
        push            = instr_valid_in && instr_ready_out;
        pop             = dec_valid_out && dec_ready_in;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end

        word   = dec_valid_out ? instr_q[rd_ptr_q] : NOP_INSTR;
        pc_out = dec_valid_out ? pc_q[rd_ptr_q] : '0;

        opcode_out     = word[6:0];
        rd_addr_out    = word[11:7];
        funct3_out     = word[14:12];
        rs1_addr_out   = word[19:15];
        rs2_addr_out   = word[24:20];
        funct7_out     = word[31:25];
        csr_addr_out   = word[31:20];
        instr_31_7_out = word[31:7];
        count_out      = count_q;
    end

    // Control state: pointers and occupancy, cleared asynchronously.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk_in) begin
        if (push) begin
            instr_q[wr_ptr_q] <= instr_in;
            pc_q[wr_ptr_q]    <= pc_in;
        end
    end

endmodule

// File: tb/tb_decode_fetch_queue.sv
// Self-checking bench: DEPTH=2 and DEPTH=4 queues share one stimulus stream and are
// each compared every cycle against a queue-based reference model.
module tb_decode_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        flush_in;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        instr_valid_in;
    logic        dec_ready_in;

    logic        rdy2, vld2, rdy4, vld4;
    logic [31:0] pc2, pc4;
    logic [6:0]  op2, op4, f7_2, f7_4;
    logic [2:0]  f3_2, f3_4;
    logic [4:0]  rs1_2, rs1_4, rs2_2, rs2_4, rd2, rd4;
    logic [11:0] csr2, csr4;
    logic [24:0] hi2, hi4;
    logic [1:0]  cnt2;
    logic [2:0]  cnt4;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m2_i[$], m2_p[$], m4_i[$], m4_p[$];

    always #5 clk_in = ~clk_in;

    decode_fetch_queue #(.DEPTH(2), .XLEN(32), .NOP_INSTR(NOP)) dut2 (
        .clk_in(clk_in), .reset_in(reset_in), .flush_in(flush_in), .instr_in(instr_in),
        .pc_in(pc_in), .instr_valid_in(instr_valid_in), .instr_ready_out(rdy2),
        .dec_ready_in(dec_ready_in), .dec_valid_out(vld2), .pc_out(pc2), .opcode_out(op2),
        .funct3_out(f3_2), .funct7_out(f7_2), .rs1_addr_out(rs1_2), .rs2_addr_out(rs2_2),
        .rd_addr_out(rd2), .csr_addr_out(csr2), .instr_31_7_out(hi2), .count_out(cnt2)
    );

    decode_fetch_queue #(.DEPTH(4), .XLEN(32), .NOP_INSTR(NOP)) dut4 (
        .clk_in(clk_in), .reset_in(reset_in), .flush_in(flush_in), .instr_in(instr_in),
        .pc_in(pc_in), .instr_valid_in(instr_valid_in), .instr_ready_out(rdy4),
        .dec_ready_in(dec_ready_in), .dec_valid_out(vld4), .pc_out(pc4), .opcode_out(op4),
        .funct3_out(f3_4), .funct7_out(f7_4), .rs1_addr_out(rs1_4), .rs2_addr_out(rs2_4),
        .rd_addr_out(rd4), .csr_addr_out(csr4), .instr_31_7_out(hi4), .count_out(cnt4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs follow directly from the model's queue contents.
    task automatic check_one(input string nm, input int cap, input int sz,
                             input logic [31:0] hw, input logic [31:0] hp,
                             input logic vo, input logic ro, input logic [31:0] pco,
                             input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [11:0] csr, input logic [24:0] hi, input int cnt);
        logic        ev, er;
        logic [31:0] w, epc;
        ev  = (sz != 0) && !flush_in;
        er  = (sz < cap) && !flush_in && !reset_in;
        w   = ev ? hw : NOP;
        epc = ev ? hp : 32'h0;
        chk({nm, ".valid"},  64'(vo),  64'(ev));
        chk({nm, ".ready"},  64'(ro),  64'(er));
        chk({nm, ".pc"},     64'(pco), 64'(epc));
        chk({nm, ".opcode"}, 64'(op),  64'(w[6:0]));
        chk({nm, ".funct3"}, 64'(f3),  64'(w[14:12]));
        chk({nm, ".funct7"}, 64'(f7),  64'(w[31:25]));
        chk({nm, ".rs1"},    64'(rs1), 64'(w[19:15]));
        chk({nm, ".rs2"},    64'(rs2), 64'(w[24:20]));
        chk({nm, ".rd"},     64'(rd),  64'(w[11:7]));
        chk({nm, ".csr"},    64'(csr), 64'(w[31:20]));
        chk({nm, ".i31_7"},  64'(hi),  64'(w[31:7]));
        chk({nm, ".count"},  64'(cnt), 64'(sz));
    endtask

    task automatic check_all();
        check_one("d2", 2, m2_i.size(), m2_i.size() != 0 ? m2_i[0] : 32'h0,
                  m2_p.size() != 0 ? m2_p[0] : 32'h0, vld2, rdy2, pc2, op2, f3_2, f7_2,
                  rs1_2, rs2_2, rd2, csr2, hi2, int'(cnt2));
        check_one("d4", 4, m4_i.size(), m4_i.size() != 0 ? m4_i[0] : 32'h0,
                  m4_p.size() != 0 ? m4_p[0] : 32'h0, vld4, rdy4, pc4, op4, f3_4, f7_4,
                  rs1_4, rs2_4, rd4, csr4, hi4, int'(cnt4));
    endtask

    task automatic clear_models();
        m2_i.delete(); m2_p.delete(); m4_i.delete(); m4_p.delete();
    endtask

    // One clock: check at the falling edge, advance the models at the rising edge.
    task automatic cycle();
        bit pop2, push2, pop4, push4;
        @(negedge clk_in);
        check_all();
        @(posedge clk_in);
        if (reset_in || flush_in) begin
            clear_models();
        end else begin
            pop2  = (m2_i.size() != 0) && dec_ready_in;
            push2 = instr_valid_in && (m2_i.size() < 2);
            pop4  = (m4_i.size() != 0) && dec_ready_in;
            push4 = instr_valid_in && (m4_i.size() < 4);
            if (pop2) begin void'(m2_i.pop_front()); void'(m2_p.pop_front()); end
            if (push2) begin m2_i.push_back(instr_in); m2_p.push_back(pc_in); end
            if (pop4) begin void'(m4_i.pop_front()); void'(m4_p.pop_front()); end
            if (push4) begin m4_i.push_back(instr_in); m4_p.push_back(pc_in); end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic r, input logic f);
        instr_valid_in = v;
        instr_in       = i;
        pc_in          = p;
        dec_ready_in   = r;
        flush_in       = f;
    endtask

    initial begin
        reset_in = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset held: NOP decode, not ready.
        cycle();
        @(negedge clk_in);
        #2 reset_in = 1'b0;
        #1 chk("rst.ready_after_release", 64'(rdy2), 64'd1);
        chk("rst.opcode", 64'(op2), 64'h13);
        cycle();

        // Single push, then pop.
        drive(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("single.valid", 64'(vld2), 64'd1);
        chk("single.rd", 64'(rd2), 64'd1);
        chk("single.csr", 64'(csr2), 64'h005);
        chk("single.pc", 64'(pc2), 64'h100);
        cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1 chk("single.count_after_pop", 64'(cnt2), 64'd0);
        cycle();

        // Fill and wrap on DEPTH=2.
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1); cycle();
        drive(1'b1, 32'h0000_0A13, 32'h200, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h0000_0B13, 32'h204, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h0000_0C13, 32'h208, 1'b0, 1'b0);
        #1;
        chk("wrap.count_full", 64'(cnt2), 64'd2);
        chk("wrap.ready_full", 64'(rdy2), 64'd0);
        cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h0000_0C13, 32'h208, 1'b1, 1'b0); cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("wrap.count_one", 64'(cnt2), 64'd1);
        chk("wrap.head_c", 64'(pc2), 64'h208);
        cycle();

        // Flush priority with a full queue and a same-cycle push/pop.
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1); cycle();
        drive(1'b1, 32'h0020_81B3, 32'h300, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h0040_8113, 32'h304, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h0060_0193, 32'h308, 1'b1, 1'b1);
        #1;
        chk("flush.opcode", 64'(op2), 64'h13);
        chk("flush.valid", 64'(vld2), 64'd0);
        chk("flush.ready", 64'(rdy2), 64'd0);
        cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1 chk("flush.count_after", 64'(cnt2), 64'd0);
        cycle();

        // Asynchronous reset between edges with a full DEPTH=2 queue.
        drive(1'b1, 32'h0000_1113, 32'h400, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h0000_2213, 32'h404, 1'b0, 1'b0); cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1 reset_in = 1'b1;
        clear_models();
        #1;
        chk("arst.count", 64'(cnt2), 64'd0);
        chk("arst.opcode", 64'(op2), 64'h13);
        chk("arst.valid", 64'(vld2), 64'd0);
        chk("arst.ready", 64'(rdy2), 64'd0);
        check_all();
        #1 reset_in = 1'b0;
        drive(1'b1, 32'h0000_3313, 32'h500, 1'b0, 1'b0); cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1 chk("arst.first_pc", 64'(pc2), 64'h500);
        cycle();

        // DEPTH=4 fill.
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1); cycle();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, $urandom, 32'h600 + 32'(4 * k), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("d4fill.count", 64'(cnt4), 64'd4);
        chk("d4fill.ready", 64'(rdy4), 64'd0);
        cycle();

        // Randomized traffic including occasional flushes.
        for (int k = 0; k < 80; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom, {$urandom_range(0, 4095), 2'b00},
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
            cycle();
        end
        // Drain and confirm emptiness.
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            cycle();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
